// File: rtl/freq_measure_ctrl.sv
// -----------------------------------------------------------------------------
// freq_measure_ctrl
//
// Measures the clock frequency against a 1 ms reference tick. On request the
// block waits for a tick (alignment), then counts clock cycles per tick period.
// It finishes when two consecutive windows agree within TOLERANCE cycles, when
// MAX_WINDOWS windows have elapsed, or when a tick fails to arrive within
// TIMEOUT_CYCLES.
//
// Ports
//   clock    in   single rising-edge clock
//   reset    in   asynchronous active-low reset
//   msTick   in   one-cycle 1 ms pulse, synchronous to clock
//   start    in   one-cycle measurement request (taken only in IDLE)
//   abort    in   cancel a measurement in progress (ALIGN/MEAS only)
//   busy     out  measurement in progress
//   done     out  one-cycle completion pulse
//   freqKHz  out  last result: clock cycles per ms (= frequency in kHz)
//   stable   out  last result met TOLERANCE
//   timeout  out  last result ended because a tick went missing
// -----------------------------------------------------------------------------
module freq_measure_ctrl #(
    parameter int          CNT_WIDTH      = 24,
    parameter int          TOLERANCE      = 2,
    parameter int          MAX_WINDOWS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = (32'd1 << CNT_WIDTH) - 32'd1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 msTick,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] freqKHz,
    output logic                 stable,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH:0]   TOL_C     = (CNT_WIDTH+1)'(TOLERANCE);
    localparam logic [3:0]           MAX_WIN_C = 4'(MAX_WINDOWS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_MEAS   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Unsigned absolute difference on CNT_WIDTH+1 bits; never wraps.
    function automatic logic [CNT_WIDTH:0] abs_diff(
        input logic [CNT_WIDTH:0] a,
        input logic [CNT_WIDTH:0] b
    );
        logic [CNT_WIDTH:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_WIDTH-1:0] prev_r, prev_nxt_s;
    logic [3:0]           win_r, win_nxt_s;
    logic [CNT_WIDTH-1:0] freq_r, freq_nxt_s;
    logic                 stable_r, stable_nxt_s;
    logic                 timeout_r, timeout_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    logic [CNT_WIDTH:0]   sample_s;
    logic [CNT_WIDTH-1:0] sample_sat_s;
    logic [CNT_WIDTH-1:0] cnt_inc_s;
    logic                 within_tol_s;
    logic                 first_win_s;
    logic                 last_win_s;
    logic                 expire_s;

    // A tick closing a window of P cycles sees cnt = P-1, hence the +1.
    assign sample_s     = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    // Only reachable when a tick lands on a saturated counter.
    assign sample_sat_s = sample_s[CNT_WIDTH] ? CNT_MAX : sample_s[CNT_WIDTH-1:0];
    assign cnt_inc_s    = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
    assign within_tol_s = (abs_diff(sample_s, {1'b0, prev_r}) <= TOL_C);
    assign first_win_s  = (win_r == 4'd0);
    assign last_win_s   = ((win_r + 4'd1) >= MAX_WIN_C);
    // A tick in the same cycle wins over the timeout.
    assign expire_s     = (cnt_r == TIMEOUT_C) && !msTick;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks tick and timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (msTick) begin
                    state_nxt_s = ST_MEAS;
                end else if (expire_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_MEAS: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (msTick) begin
                    if (first_win_s) begin
                        state_nxt_s = ST_MEAS;
                    end else if (within_tol_s || last_win_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_MEAS;
                    end
                end else if (expire_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_MEAS;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; results hold unless a rule updates them.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        prev_nxt_s    = prev_r;
        win_nxt_s     = win_r;
        freq_nxt_s    = freq_r;
        stable_nxt_s  = stable_r;
        timeout_nxt_s = timeout_r;
        busy_nxt_s    = (state_nxt_s == ST_ALIGN) || (state_nxt_s == ST_MEAS);
        done_nxt_s    = (state_nxt_s == ST_FINISH);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cnt_nxt_s     = CNT_ZERO;
                    prev_nxt_s    = CNT_ZERO;
                    win_nxt_s     = 4'd0;
                    stable_nxt_s  = 1'b0;
                    timeout_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_ALIGN: begin
                if (abort) begin
                    cnt_nxt_s = cnt_r;
                end else if (msTick) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (expire_s) begin
                    timeout_nxt_s = 1'b1;
                    freq_nxt_s    = CNT_ZERO;
                    stable_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_MEAS: begin
                if (abort) begin
                    cnt_nxt_s = cnt_r;
                end else if (msTick) begin
                    cnt_nxt_s = CNT_ZERO;
                    win_nxt_s = win_r + 4'd1;
                    if (first_win_s) begin
                        prev_nxt_s = sample_sat_s;
                    end else if (within_tol_s) begin
                        freq_nxt_s   = sample_sat_s;
                        stable_nxt_s = 1'b1;
                    end else begin
                        prev_nxt_s = sample_sat_s;
                        if (last_win_s) begin
                            freq_nxt_s   = sample_sat_s;
                            stable_nxt_s = 1'b0;
                        end else begin
                            freq_nxt_s = freq_r;
                        end
                    end
                end else if (expire_s) begin
                    timeout_nxt_s = 1'b1;
                    freq_nxt_s    = CNT_ZERO;
                    stable_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_FINISH: begin
                cnt_nxt_s = cnt_r;
            end
            default: begin
                cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r     <= CNT_ZERO;
            prev_r    <= CNT_ZERO;
            win_r     <= 4'd0;
            freq_r    <= CNT_ZERO;
            stable_r  <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            prev_r    <= prev_nxt_s;
            win_r     <= win_nxt_s;
            freq_r    <= freq_nxt_s;
            stable_r  <= stable_nxt_s;
            timeout_r <= timeout_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign freqKHz = freq_r;
    assign stable  = stable_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for freq_measure_ctrl: directed scenarios plus randomized tick
// schedules, each checked against a window-level reference model.
// -----------------------------------------------------------------------------
module tb_freq_measure_ctrl;

    localparam int CW   = 24;
    localparam int TOL  = 2;
    localparam int MAXW = 4;
    localparam int TO   = 1000;

    logic          clock;
    logic          reset;
    logic          msTick;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [CW-1:0] freqKHz;
    logic          stable;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int per_a [16];
    int per_n = 0;

    int last_freq   = 0;
    int last_stable = 0;

    freq_measure_ctrl #(
        .CNT_WIDTH      (CW),
        .TOLERANCE      (TOL),
        .MAX_WINDOWS    (MAXW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .msTick  (msTick),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .freqKHz (freqKHz),
        .stable  (stable),
        .timeout (timeout)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_per(input int p0, input int p1, input int p2, input int p3, input int n);
        per_a[0] = p0;
        per_a[1] = p1;
        per_a[2] = p2;
        per_a[3] = p3;
        per_n    = n;
    endtask

    // Reference: first tick at edge a after acceptance (edge 0), then periods
    // per_a[]. Returns the edge after which done is high and the result.
    function automatic void model(input int a, output int d, output int f,
                                  output int s, output int to);
        int t;
        int prev;
        int diff;
        d = -1; f = 0; s = 0; to = 0;
        if (a > TO + 1) begin
            d = TO + 1; to = 1;
            return;
        end
        t = a;
        prev = 0;
        for (int k = 0; k < per_n; k++) begin
            if (per_a[k] > TO + 1) begin
                d = t + TO + 1; to = 1;
                return;
            end
            t = t + per_a[k];
            diff = per_a[k] - prev;
            if (diff < 0) diff = -diff;
            if (k == 0) begin
                prev = per_a[k];
            end else if (diff <= TOL) begin
                d = t; f = per_a[k]; s = 1;
                return;
            end else if (k + 1 == MAXW) begin
                d = t; f = per_a[k];
                return;
            end else begin
                prev = per_a[k];
            end
        end
    endfunction

    // Caller is at a falling edge. Start, drive ticks, wait for done, check.
    task automatic run_meas(input string tag, input int a, input bit tick_at_start,
                            input bit noise);
        int d, f, s, to;
        int got, next_tick, idx, busy_low;
        model(a, d, f, s, to);
        start  = 1'b1;
        msTick = tick_at_start;
        abort  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        msTick = 1'b0;
        check_val({tag, "_busy_start"}, 32'(busy), 32'd1);
        got = -1; busy_low = 0; next_tick = a; idx = 0;
        for (int e = 1; e <= d + 20; e++) begin
            msTick = (e == next_tick);
            if (e == next_tick) begin
                next_tick = (idx < per_n) ? (next_tick + per_a[idx]) : -1;
                idx++;
            end
            start = noise && ($urandom_range(0, 7) == 0);
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                got = e;
                break;
            end
            if (!busy) busy_low++;
        end
        msTick = 1'b0;
        check_val({tag, "_done_edge"}, 32'(got), 32'(d));
        check_val({tag, "_busy_run"}, 32'(busy_low), 32'd0);
        check_val({tag, "_freq"}, 32'(freqKHz), 32'(f));
        check_val({tag, "_stable"}, 32'(stable), 32'(s));
        check_val({tag, "_timeout"}, 32'(timeout), 32'(to));
        check_val({tag, "_busy_fin"}, 32'(busy), 32'd0);
        // A start during the done cycle must be ignored.
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check_val({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_freq_hold"}, 32'(freqKHz), 32'(f));
        last_freq   = f;
        last_stable = s;
    endtask

    // Abort at edge at_edge (with a coincident tick). at_edge < a -> ALIGN.
    task automatic run_abort(input string tag, input int a, input int at_edge);
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int e = 1; e <= at_edge; e++) begin
            msTick = (e == a) || (e == at_edge);
            abort  = (e == at_edge);
            @(posedge clock);
            @(negedge clock);
            if (done) done_seen++;
            if (e == at_edge - 1) check_val({tag, "_busy_pre"}, 32'(busy), 32'd1);
        end
        abort  = 1'b0;
        msTick = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_freq"}, 32'(freqKHz), 32'(last_freq));
        check_val({tag, "_stable"}, 32'(stable), 32'd0);
        check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
        repeat (8) begin
            msTick = 1'b1;
            @(posedge clock);
            @(negedge clock);
            if (done) done_seen++;
        end
        msTick = 1'b0;
        check_val({tag, "_no_done"}, 32'(done_seen), 32'd0);
        check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
        last_stable = 0;
    endtask

    // Reset in the middle of MEAS; leaves reset released at a falling edge.
    task automatic run_reset_mid(input string tag);
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            msTick = (e == 5);
            @(posedge clock);
            @(negedge clock);
        end
        msTick = 1'b0;
        check_val({tag, "_busy_pre"}, 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_freq"}, 32'(freqKHz), 32'd0);
        check_val({tag, "_stable"}, 32'(stable), 32'd0);
        check_val({tag, "_timeout"}, 32'(timeout), 32'd0);
        repeat (3) begin
            msTick = 1'b1;
            @(posedge clock);
            @(negedge clock);
            if (done) done_seen++;
        end
        msTick = 1'b0;
        check_val({tag, "_no_done"}, 32'(done_seen), 32'd0);
        reset       = 1'b1;
        last_freq   = 0;
        last_stable = 0;
    endtask

    // Main sequence.
    initial begin
        int mode, base, step;
        reset  = 1'b0;
        start  = 1'b0;
        msTick = 1'b0;
        abort  = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_freq", 32'(freqKHz), 32'd0);
        check_val("rst_stable", 32'(stable), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);

        // Release and start on the same first active edge.
        reset = 1'b1;
        set_per(50, 50, 50, 50, 4);
        run_meas("steady", 7, 1'b0, 1'b0);

        // Abort in IDLE changes nothing.
        abort = 1'b1;
        @(posedge clock);
        @(negedge clock);
        abort = 1'b0;
        check_val("idle_abort_busy", 32'(busy), 32'd0);
        check_val("idle_abort_stable", 32'(stable), 32'(last_stable));
        check_val("idle_abort_freq", 32'(freqKHz), 32'(last_freq));

        set_per(50, 55, 54, 60, 4);
        run_meas("jitter", 12, 1'b0, 1'b0);
        set_per(50, 60, 70, 80, 4);
        run_meas("never", 3, 1'b0, 1'b0);
        set_per(50, 50, 50, 50, 4);
        run_meas("coinc", 10, 1'b1, 1'b1);

        run_abort("abort_meas", 5, 40);
        run_abort("abort_align", 30, 10);

        set_per(50, 50, 50, 50, 0);
        run_meas("to_align", 5000, 1'b0, 1'b0);
        set_per(50, 50, 50, 50, 4);
        run_meas("tick_at_1000", 1001, 1'b0, 1'b0);
        set_per(60, 2000, 0, 0, 2);
        run_meas("to_meas", 3, 1'b0, 1'b0);
        set_per(1001, 1000, 0, 0, 2);
        run_meas("meas_tick_1000", 3, 1'b0, 1'b0);

        run_reset_mid("rst_mid");
        set_per(50, 50, 50, 50, 4);
        run_meas("after_rst", 4, 1'b0, 1'b0);

        for (int it = 0; it < 25; it++) begin
            mode = int'($urandom_range(0, 2));
            base = int'($urandom_range(20, 150));
            step = int'($urandom_range(3, 10));
            for (int k = 0; k < 4; k++) begin
                if (mode == 0) begin
                    per_a[k] = base + int'($urandom_range(0, 4)) - 2;
                end else if (mode == 1) begin
                    per_a[k] = base + k * step;
                end else begin
                    per_a[k] = int'($urandom_range(20, 150));
                end
            end
            per_n = 4;
            run_meas("rand", int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
